// File: rtl/one2two_demux_buf.sv
// 1-to-2 valid/ready demux: sel=1 routes a beat to port A, sel=0 to port B.
// Each port has its own FIFO and a wrapping accepted-beat counter.
module one2two_demux_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop_rdy,
  output logic              full,
  output logic              valid,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       occ;
  logic              pop;

  assign valid = (occ != '0);
  assign full  = (occ == FULL_OCC);
  assign pop   = valid & pop_rdy;
  // Empty FIFO presents zero rather than a stale entry.
  assign rdata = valid ? mem[rptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
        cnt  <= cnt + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end
endmodule

module one2two_demux_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_sel_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] a_data_o,
  output logic              a_valid_o,
  input  logic              a_ready_i,
  output logic [DATA_W-1:0] b_data_o,
  output logic              b_valid_o,
  input  logic              b_ready_i,
  output logic [CNT_W-1:0]  a_cnt_o,
  output logic [CNT_W-1:0]  b_cnt_o
);
  // Port index 0 is A, 1 is B.
  logic [1:0]             full, valid, push, pop_rdy;
  logic [1:0][DATA_W-1:0] rdata;
  logic [1:0][CNT_W-1:0]  cnt;
  logic                   run;

  // Holds ready low through reset and until the first edge after release.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) run <= 1'b0;
    else          run <= 1'b1;
  end

  assign in_ready_o = run & (in_sel_i ? !full[0] : !full[1]);
  assign pop_rdy    = {b_ready_i, a_ready_i};

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam logic SEL_VAL = (p == 0);
    assign push[p] = in_valid_i & in_ready_o & (in_sel_i == SEL_VAL);
    one2two_demux_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clk     (clk_i),
      .rst_n   (rst_n_i),
      .push    (push[p]),
      .wdata   (in_data_i),
      .pop_rdy (pop_rdy[p]),
      .full    (full[p]),
      .valid   (valid[p]),
      .rdata   (rdata[p]),
      .cnt     (cnt[p])
    );
  end

  assign a_data_o  = rdata[0];
  assign b_data_o  = rdata[1];
  assign a_valid_o = valid[0];
  assign b_valid_o = valid[1];
  assign a_cnt_o   = cnt[0];
  assign b_cnt_o   = cnt[1];
endmodule

// File: tb/tb_one2two_demux_buf.sv
// Bench for one2two_demux_buf: queue-based port model checked every negedge,
// plus directed scenarios with literal expectations.
module tb_one2two_demux_buf;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_sel = 1'b0, in_valid = 1'b0, a_ready = 1'b0, b_ready = 1'b0;
  logic              in_ready, a_valid, b_valid;
  logic [DATA_W-1:0] a_data, b_data;
  logic [CNT_W-1:0]  a_cnt, b_cnt;

  int checks = 0;
  int errors = 0;

  one2two_demux_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_data_i(in_data), .in_sel_i(in_sel),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .a_data_o(a_data),
    .a_valid_o(a_valid), .a_ready_i(a_ready), .b_data_o(b_data),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .a_cnt_o(a_cnt), .b_cnt_o(b_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one queue per port, beat counters, and an alive flag for ready after reset.
  logic [DATA_W-1:0] qa[$], qb[$];
  logic [CNT_W-1:0]  mca = '0, mcb = '0;
  bit                alive = 1'b0;
  bit                m_acc, m_pa, m_pb;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      qa.delete(); qb.delete();
      mca = '0; mcb = '0; alive = 1'b0;
    end else begin
      m_acc = in_valid && alive && (in_sel ? (qa.size() < DEPTH) : (qb.size() < DEPTH));
      m_pa  = (qa.size() > 0) && a_ready;
      m_pb  = (qb.size() > 0) && b_ready;
      if (m_pa) void'(qa.pop_front());
      if (m_pb) void'(qb.pop_front());
      if (m_acc) begin
        if (in_sel) begin qa.push_back(in_data); mca = mca + 1'b1; end
        else        begin qb.push_back(in_data); mcb = mcb + 1'b1; end
      end
      alive = 1'b1;
    end
  end

  function automatic logic m_ready();
    return alive && (in_sel ? (qa.size() < DEPTH) : (qb.size() < DEPTH));
  endfunction

  initial forever begin
    @(negedge clk);
    chk("cmp_in_ready", 32'(in_ready), 32'(m_ready()));
    chk("cmp_a_valid", 32'(a_valid), 32'(qa.size() > 0));
    chk("cmp_b_valid", 32'(b_valid), 32'(qb.size() > 0));
    chk("cmp_a_data", 32'(a_data), (qa.size() > 0) ? 32'(qa[0]) : 32'h0);
    chk("cmp_b_data", 32'(b_data), (qb.size() > 0) ? 32'(qb[0]) : 32'h0);
    chk("cmp_a_cnt", 32'(a_cnt), 32'(mca));
    chk("cmp_b_cnt", 32'(b_cnt), 32'(mcb));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [DATA_W-1:0] d);
    in_valid = v; in_sel = s; in_data = d;
    #1;
  endtask

  int a_acc;

  initial begin
    // Reset held, then released, then idle for 5 cycles.
    repeat (3) step();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_a_valid", 32'(a_valid), 32'h0);
    rst_n = 1'b1;
    repeat (5) step();
    chk("idle_in_ready", 32'(in_ready), 32'h1);
    chk("idle_cnts", {16'(a_cnt), 16'(b_cnt)}, 32'h0);
    chk("idle_valids", 32'({a_valid, b_valid}), 32'h0);

    // One beat to each port with free-flowing consumers.
    a_ready = 1'b1; b_ready = 1'b1;
    drive(1'b1, 1'b1, 8'hA5); step();
    chk("first_a_valid", 32'(a_valid), 32'h1);
    chk("first_a_data", 32'(a_data), 32'hA5);
    drive(1'b1, 1'b0, 8'h3C); step();
    chk("first_b_data", 32'(b_data), 32'h3C);
    chk("first_b_valid", 32'(b_valid), 32'h1);
    drive(1'b0, 1'b0, 8'h00); step();
    chk("first_cnts", {16'(a_cnt), 16'(b_cnt)}, {16'd1, 16'd1});
    chk("first_drained", 32'({a_valid, b_valid}), 32'h0);

    // Fill A under backpressure; B still flows; full+pop refuses the push.
    a_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h01); step();
    drive(1'b1, 1'b1, 8'h02); step();
    drive(1'b1, 1'b1, 8'h03);
    chk("a_full_stall", 32'(in_ready), 32'h0);
    drive(1'b1, 1'b0, 8'h77);
    chk("b_bypass_ready", 32'(in_ready), 32'h1);
    step();
    chk("b_bypass_data", 32'(b_data), 32'h77);
    drive(1'b1, 1'b1, 8'h03);
    a_ready = 1'b1;
    chk("full_pop_refuse", 32'(in_ready), 32'h0);
    step();
    chk("after_pop_head", 32'(a_data), 32'h02);
    chk("after_pop_ready", 32'(in_ready), 32'h1);
    chk("after_pop_cnt", 32'(a_cnt), 32'd3);
    step();
    chk("third_head", 32'(a_data), 32'h03);
    chk("third_cnt", 32'(a_cnt), 32'd4);
    drive(1'b0, 1'b0, 8'h00); step();
    chk("a_drained", 32'(a_valid), 32'h0);
    chk("b_cnt_2", 32'(b_cnt), 32'd2);

    // Async reset with two beats queued in A.
    a_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h11); step();
    drive(1'b1, 1'b1, 8'h22); step();
    drive(1'b0, 1'b0, 8'h00);
    chk("pre_rst_a_data", 32'(a_data), 32'h11);
    #1 rst_n = 1'b0;
    #1;
    chk("async_a_valid", 32'(a_valid), 32'h0);
    chk("async_a_data", 32'(a_data), 32'h0);
    chk("async_cnts", {16'(a_cnt), 16'(b_cnt)}, 32'h0);
    chk("async_in_ready", 32'(in_ready), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    a_ready = 1'b1;
    step();
    chk("no_stale_a", 32'(a_valid), 32'h0);
    chk("post_rst_ready", 32'(in_ready), 32'h1);

    // Drive 2^CNT_W-1 A accepts under random backpressure and mixed B traffic.
    a_acc = 0;
    for (int i = 0; i < 400 && a_acc < (1 << CNT_W) - 1; i++) begin
      a_ready = 1'($urandom_range(0, 1));
      b_ready = 1'($urandom_range(0, 1));
      drive(1'b1, 1'($urandom_range(0, 2) != 0), 8'($urandom));
      if (in_ready && in_sel) a_acc++;
      step();
    end
    drive(1'b0, 1'b0, 8'h00);
    chk("preload_done", 32'(a_acc), 32'((1 << CNT_W) - 1));
    chk("preload_cnt", 32'(a_cnt), 32'((1 << CNT_W) - 1));
    a_ready = 1'b1;
    step();
    drive(1'b1, 1'b1, 8'h5A);
    chk("wrap_ready", 32'(in_ready), 32'h1);
    step();
    drive(1'b0, 1'b0, 8'h00);
    chk("wrap_cnt", 32'(a_cnt), 32'h0);
    b_ready = 1'b1;
    repeat (4) step();
    chk("final_drained", 32'({a_valid, b_valid}), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
